// File: rtl/shreg_seq_ctrl.sv
// Command sequencer for an 8-bit universal shift register: drives mode, parallel data and
// serial fill pins for a load/shift/rotate command, then pulses done.
module shreg_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_fill,
   output logic             busy,
   output logic             done,
   output logic             cmd_err,
   output logic             a0,
   output logic             a1,
   output logic [WIDTH-1:0] d,
   output logic             dl,
   output logic             dr,
   input  logic [WIDTH-1:0] q
);

   localparam logic [2:0] OpLoad = 3'd0;
   localparam logic [2:0] OpShl  = 3'd1;
   localparam logic [2:0] OpShr  = 3'd2;
   localparam logic [2:0] OpRol  = 3'd3;
   localparam logic [2:0] OpRor  = 3'd4;
   localparam logic [2:0] OpAsr  = 3'd5;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               fill_q, fill_d;
   logic               err_q, err_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OpLoad;
         cnt_q   <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fill_d  = fill_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               fill_d = cmd_fill;
               err_d  = 1'b0;
               cnt_d  = '0;
               if (cmd_op == OpLoad) begin
                  state_d = StLoad;
               end else if (cmd_op > OpAsr) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else if (cmd_amt == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d   = cmd_amt;
                  state_d = StShift;
               end
            end
         end
         StLoad: state_d = StDone;
         StShift: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control outputs decode from registered state only.
   always_comb begin
      a0        = 1'b0;
      a1        = 1'b0;
      busy      = 1'b1;
      cmd_ready = 1'b0;
      done      = 1'b0;
      cmd_err   = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy      = 1'b0;
            cmd_ready = 1'b1;
         end
         StLoad: begin
            a0 = 1'b1;
            a1 = 1'b1;
         end
         StShift: begin
            if (op_q == OpShl || op_q == OpRol) a1 = 1'b1;
            else                                a0 = 1'b1;
         end
         StDone: begin
            done    = 1'b1;
            cmd_err = err_q;
         end
         default: ;
      endcase
   end

   // Serial fill follows the live register output so rotates and ASR see each new value.
   always_comb begin
      dl = 1'b0;
      dr = 1'b0;
      case (op_q)
         OpShl:   dl = fill_q;
         OpRol:   dl = q[WIDTH-1];
         OpShr:   dr = fill_q;
         OpRor:   dr = q[0];
         OpAsr:   dr = q[WIDTH-1];
         default: ;
      endcase
   end

   assign d = data_q;

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Self-checking bench: behavioural shift register in the loop, expected results queued per command.
module tb_shreg_seq_ctrl;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic [2:0]       cmd_op = 3'd0;
   logic [CNT_W-1:0] cmd_amt = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic             cmd_fill = 1'b0;
   logic             cmd_ready, busy, done, cmd_err, a0, a1, dl, dr;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q = '0;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] model_q = 8'h00;
   logic [7:0] exp_q_fifo[$];
   logic       exp_err_fifo[$];

   shreg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .cmd_data  (cmd_data),
      .cmd_fill  (cmd_fill),
      .busy      (busy),
      .done      (done),
      .cmd_err   (cmd_err),
      .a0        (a0),
      .a1        (a1),
      .d         (d),
      .dl        (dl),
      .dr        (dr),
      .q         (q)
   );

   always #5 clock = ~clock;

   // External universal shift register
   always @(posedge clock) begin
      case ({a1, a0})
         2'b11:   q <= d;
         2'b10:   q <= {q[6:0], dl};
         2'b01:   q <= {dr, q[7:1]};
         default: q <= q;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ref_step(input logic [2:0] op, input logic [7:0] v,
                                           input logic f);
      case (op)
         3'd1:    return {v[6:0], f};
         3'd2:    return {f, v[7:1]};
         3'd3:    return {v[6:0], v[7]};
         3'd4:    return {v[0], v[7:1]};
         3'd5:    return {v[7], v[7:1]};
         default: return v;
      endcase
   endfunction

   task automatic run_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                          input logic fill, input bit hold, input string name);
      int exp_lat, exp_modes, cyc, modes;
      bit seen, hs_bad;
      logic [7:0] eq;
      logic ee;
      ee = (op > 3'd5);
      if (op == 3'd0) begin
         model_q = data; exp_lat = 2; exp_modes = 1;
      end else if (ee) begin
         exp_lat = 1; exp_modes = 0;
      end else begin
         for (int i = 0; i < int'(amt); i++) model_q = ref_step(op, model_q, fill);
         exp_lat = int'(amt) + 1; exp_modes = int'(amt);
      end
      exp_q_fifo.push_back(model_q);
      exp_err_fifo.push_back(ee);

      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++; $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_fill = fill;
      @(posedge clock);
      @(negedge clock);
      if (hold) begin
         cmd_op = 3'd0; cmd_amt = 3'd1; cmd_data = ~data; cmd_fill = ~fill;
      end else begin
         cmd_valid = 1'b0;
      end
      seen = 0; modes = 0; cyc = 1; hs_bad = 0;
      while (!seen && cyc <= 20) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if ({a1, a0} !== 2'b00) modes++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1;
            cyc++;
            @(negedge clock);
         end
      end
      cmd_valid = 1'b0;
      eq = exp_q_fifo.pop_front();
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL %s done_timeout: got none want done within 20 cycles", name);
         void'(exp_err_fifo.pop_front());
         return;
      end
      if (q !== eq) begin
         n_bad++; $display("FAIL %s q: got %h want %h", name, q, eq);
      end
      n_cmp++;
      if (cmd_err !== exp_err_fifo.pop_front()) begin
         n_bad++; $display("FAIL %s cmd_err: got %b want %b", name, cmd_err, ee);
      end
      n_cmp++;
      if (cyc != exp_lat) begin
         n_bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      n_cmp++;
      if (modes != exp_modes) begin
         n_bad++; $display("FAIL %s mode_cycles: got %0d want %0d", name, modes, exp_modes);
      end
      n_cmp++;
      if (hs_bad || busy !== 1'b1 || cmd_ready !== 1'b0 || d !== data) begin
         n_bad++; $display("FAIL %s busy_phase: got hs_bad=%b busy=%b ready=%b d=%h want 0 1 0 %h",
                           name, hs_bad, busy, cmd_ready, d, data);
      end
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || {a1, a0} !== 2'b00) begin
         n_bad++; $display("FAIL %s after_done: got done=%b ready=%b busy=%b a=%b%b want 0 1 0 00",
                           name, done, cmd_ready, busy, a1, a0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clock);
      @(negedge clock);
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_status: got ready=%b busy=%b done=%b err=%b want 1 0 0 0",
                           cmd_ready, busy, done, cmd_err);
      end
      n_cmp++;
      if ({a1, a0} !== 2'b00 || d !== 8'h00 || dl !== 1'b0 || dr !== 1'b0) begin
         n_bad++; $display("FAIL reset_pins: got a=%b%b d=%h dl=%b dr=%b want 00 00 0 0",
                           a1, a0, d, dl, dr);
      end
      cmd_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_no_accept: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_load();
      run_cmd(3'd0, 3'd0, 8'hA5, 1'b0, 0, "load_a5");
   endtask

   task automatic test_rotate();
      run_cmd(3'd3, 3'd3, 8'h00, 1'b0, 0, "rol3");
      run_cmd(3'd4, 3'd0, 8'h00, 1'b0, 0, "ror0");
   endtask

   task automatic test_shift_fill();
      run_cmd(3'd2, 3'd2, 8'h00, 1'b0, 0, "shr2");
      run_cmd(3'd0, 3'd0, 8'h80, 1'b0, 0, "load_80");
      run_cmd(3'd5, 3'd3, 8'h00, 1'b0, 0, "asr3");
      run_cmd(3'd0, 3'd0, 8'h0F, 1'b0, 0, "load_0f");
      run_cmd(3'd1, 3'd4, 8'h00, 1'b1, 0, "shl4_fill1");
      run_cmd(3'd4, 3'd0, 8'h00, 1'b0, 0, "ror0_ff");
   endtask

   task automatic test_reserved();
      run_cmd(3'd6, 3'd3, 8'h11, 1'b0, 0, "rsv6");
      run_cmd(3'd7, 3'd0, 8'h22, 1'b1, 0, "rsv7");
   endtask

   task automatic test_back_to_back();
      run_cmd(3'd0, 3'd0, 8'h3C, 1'b0, 0, "load_3c");
      run_cmd(3'd4, 3'd5, 8'h00, 1'b0, 1, "ror5_hold");
      run_cmd(3'd2, 3'd7, 8'h00, 1'b1, 0, "shr7_fill1");
      run_cmd(3'd3, 3'd7, 8'h00, 1'b0, 0, "rol7");
   endtask

   task automatic test_mid_reset();
      logic [7:0] eq;
      run_cmd(3'd0, 3'd0, 8'h81, 1'b0, 0, "mr_load");
      for (int i = 0; i < 3; i++) model_q = ref_step(3'd1, model_q, 1'b1);
      exp_q_fifo.push_back(model_q);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_amt = 3'd7; cmd_fill = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clock);
      eq = exp_q_fifo.pop_front();
      n_cmp++;
      if ({a1, a0} !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         n_bad++; $display("FAIL midrst_state: got a=%b%b busy=%b done=%b ready=%b want 00 0 0 1",
                           a1, a0, busy, done, cmd_ready);
      end
      n_cmp++;
      if (q !== eq || d !== 8'h00) begin
         n_bad++; $display("FAIL midrst_q: got q=%h d=%h want q=%h d=00", q, d, eq);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      n_cmp++;
      if (q !== eq || done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL midrst_hold: got q=%h done=%b busy=%b want q=%h 0 0",
                           q, done, busy, eq);
      end
      run_cmd(3'd0, 3'd0, 8'h5A, 1'b0, 0, "post_rst_load");
   endtask

   initial begin
      test_reset();
      test_load();
      test_rotate();
      test_shift_fill();
      test_reserved();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
